// File: rtl/cim_aes_array_responder.sv
// cim_aes_array_responder
//   Array-side responder for the bit-serial CIM AES core. It holds the NR+1
//   round keys and the AES S-box, and answers the core's AddRoundKey bit-slice
//   requests (IN) and S-box lookups (DEMUX_ADD / RWL_DEC_ADD) on the 16 RIO
//   read lanes. One instance per core, on the core clock.
// Ports
//   CLK          core clock, all logic on posedge
//   RSTn         synchronous reset, active low
//   KEY_WE       round-key write strobe, honoured only while not BUSY
//   KEY_ADDR     round-key index 0..NR, larger indices are dropped
//   KEY_DIN      round key, byte b = KEY_DIN[127-8b -: 8]
//   START        begin one encryption response sequence (IDLE/DONE only)
//   IN           core bit-slice request word
//   DEMUX_ADD    lane j = DEMUX_ADD[3j+2:3j]
//   RWL_DEC_ADD  lane j = RWL_DEC_ADD[6j+5:6j]
//   RIO          registered read data, lane j = RIO[8j+7:8j]
//   ROUND        round whose key is currently served
//   BUSY         sequence in progress (ARK or LOOKUP)
//   DONE         sequence complete, cleared by the next START
//   ADDR_ERR     sticky out-of-range lookup flag, cleared by START
module cim_aes_array_responder #(
   parameter int unsigned NR         = 10,
   parameter int unsigned ARK_CYCLES = 8
) (
   input  logic         CLK,
   input  logic         RSTn,
   input  logic         KEY_WE,
   input  logic [3:0]   KEY_ADDR,
   input  logic [127:0] KEY_DIN,
   input  logic         START,
   input  logic [15:0]  IN,
   input  logic [47:0]  DEMUX_ADD,
   input  logic [95:0]  RWL_DEC_ADD,
   output logic [127:0] RIO,
   output logic [3:0]   ROUND,
   output logic         BUSY,
   output logic         DONE,
   output logic         ADDR_ERR
);

   localparam int unsigned CW = (ARK_CYCLES > 1) ? $clog2(ARK_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(ARK_CYCLES - 1);
   localparam logic [3:0]    NR_L     = 4'(NR);

   localparam logic [7:0] SBOX [256] = '{
      8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
      8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
      8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
      8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
      8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
      8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
      8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
      8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
      8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
      8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
      8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
      8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
      8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
      8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
      8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
      8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
   };

   typedef enum logic [1:0] {S_IDLE, S_ARK, S_LOOKUP, S_DONE} state_t;

   state_t          state, state_nxt;
   logic [CW-1:0]   cnt, cnt_nxt;
   logic [3:0]      round_nxt;
   logic [127:0]    rio_nxt;
   logic            err_nxt;
   logic [127:0]    key_mem [NR+1];
   logic [127:0]    cur_key;
   logic [127:0]    ark_word;
   logic [127:0]    lookup_word;
   logic            lookup_err;
   logic            key_wr;

   assign BUSY   = (state == S_ARK) || (state == S_LOOKUP);
   assign DONE   = (state == S_DONE);
   assign key_wr = KEY_WE && !BUSY && (KEY_ADDR <= NR_L);

   // Lane k gathers bit k of the even key bytes (byte 0 in the MSB), lane
   // k+8 the odd bytes; each lane is masked by the opposite half of IN.
   always_comb begin
      cur_key  = key_mem[ROUND];
      ark_word = '0;
      for (int unsigned k = 0; k < 8; k++) begin
         for (int unsigned i = 0; i < 8; i++) begin
            ark_word[8*k + 7 - i]     = cur_key[120 - 16*i + k] ^ IN[k+8];
            ark_word[8*(k+8) + 7 - i] = cur_key[112 - 16*i + k] ^ IN[k];
         end
      end
   end

   // Address bit 2 is outside the array; the lane still reads the truncated index.
   always_comb begin
      lookup_word = '0;
      lookup_err  = 1'b0;
      for (int unsigned j = 0; j < 16; j++) begin
         lookup_word[8*j +: 8] = SBOX[{DEMUX_ADD[3*j +: 2], RWL_DEC_ADD[6*j +: 6]}];
         lookup_err            = lookup_err | DEMUX_ADD[3*j + 2];
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      round_nxt = ROUND;
      rio_nxt   = RIO;
      err_nxt   = ADDR_ERR;
      case (state)
         S_IDLE, S_DONE: begin
            if (START) begin
               state_nxt = S_ARK;
               cnt_nxt   = '0;
               round_nxt = '0;
               err_nxt   = 1'b0;
            end
         end
         S_ARK: begin
            rio_nxt = ark_word;
            if (cnt == CNT_LAST) begin
               cnt_nxt   = '0;
               state_nxt = (ROUND >= NR_L) ? S_DONE : S_LOOKUP;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         S_LOOKUP: begin
            rio_nxt   = lookup_word;
            err_nxt   = ADDR_ERR | lookup_err;
            round_nxt = ROUND + 1'b1;
            cnt_nxt   = '0;
            state_nxt = S_ARK;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         state    <= S_IDLE;
         cnt      <= '0;
         ROUND    <= '0;
         RIO      <= '0;
         ADDR_ERR <= 1'b0;
         for (int unsigned i = 0; i <= NR; i++) begin
            key_mem[i] <= '0;
         end
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         ROUND    <= round_nxt;
         RIO      <= rio_nxt;
         ADDR_ERR <= err_nxt;
         if (key_wr) begin
            key_mem[KEY_ADDR] <= KEY_DIN;
         end
      end
   end

endmodule
